mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory stage plus MEM/WB pipeline register for the PA-RISC pipeline. Consumes the EX/MEM register outputs and performs big-endian byte/halfword/word loads and stores on an internal data RAM. Selects load data or ALU result and registers the writeback bundle (data, destination, RF load enable) for the WB stage. A testbench preload port fills the RAM before execution.

## Interface
- ADDR_BITS, 8, RAM address width in bytes (2^ADDR_BITS bytes, 256 by default)
- clk  in  1  rising-edge clock
- Reset  in  1  reset Reset, synchronous, active-high; clock clk
- MEM_RB_in  in  32  store data
- MEM_ALU_OUT_in  in  32  effective address for loads/stores; result value otherwise
- MEM_RD_in  in  5  destination register
- MEM_RAM_CTRL_in  in  4  [3]=E access enable, [2]=RW (1 store, 0 load), [1:0]=size (00 byte, 01 half, 10 word, 11 treated as word)
- MEM_L_in  in  1  1 = write back load data, 0 = write back ALU result
- MEM_RF_LE_in  in  1  register-file load enable
- PRE_EN  in  1  preload byte write strobe
- PRE_ADDR  in  ADDR_BITS  preload byte address
- PRE_DATA  in  8  preload byte
- MEM_FWD_DATA_out  out  32  combinational writeback value of the instruction currently in MEM (for forwarding)
- WB_DATA_out  out  32  registered writeback value
- WB_RD_out  out  5  registered destination
- WB_RF_LE_out  out  1  registered RF load enable
- WB_MISALIGN_out  out  1  registered misaligned-access flag

## Operation
- Address A = MEM_ALU_OUT_in[ADDR_BITS-1:0]; upper bits ignored (wrap-around modulo 2^ADDR_BITS). Multi-byte accesses wrap at the top address.
- Big-endian: word at A = {mem[A], mem[A+1], mem[A+2], mem[A+3]}; half = {mem[A], mem[A+1]}.
- Misaligned: half with A[0]=1, word with A[1:0]!=0. Loads use the force-aligned address (low bits cleared). Stores are suppressed. The flag is set for either case.
- Load (E=1, RW=0): byte and half are zero-extended to 32 bits. Load data is a combinational read of the array.
- Store (E=1, RW=1): writes MEM_RB_in[7:0] (byte), [15:0] (half) or [31:0] (word) in big-endian order at the posedge.
- E=0: no RAM access. Load data reads as 0. Misalign flag is 0.
- MEM_FWD_DATA_out = MEM_L_in ? load data : MEM_ALU_OUT_in.
- Preload: when PRE_EN=1, mem[PRE_ADDR] <= PRE_DATA at the posedge. This is accepted even during Reset. A pipeline store in the same cycle is dropped (preload priority).
- Reset clears WB outputs only, never the RAM array. RAM power-up contents are 0 in simulation.

## Timing
- Latency: inputs sampled at posedge N appear on WB_* after that edge (1 cycle). The array write also happens at edge N.
- Store at cycle N followed by a load of the same address at cycle N+1 returns the new data. There is no same-cycle read-after-write (single instruction per cycle).
- Reset=1 at a posedge: WB_DATA_out=0, WB_RD_out=0, WB_RF_LE_out=0, WB_MISALIGN_out=0. A pipeline store in that cycle is suppressed. Preload is still honoured.
- Reset asserted mid-sequence discards the in-flight instruction; the RAM keeps all prior writes.
- MEM_FWD_DATA_out has no reset dependency (purely combinational on inputs and array).

## Test plan
- Preload bytes 0x10..0x13 = 11,22,33,44. Load word A=0x10, L=1, RF_LE=1, RD=5 -> next cycle WB_DATA_out=0x11223344, WB_RD_out=5, WB_RF_LE_out=1.
- Same preload: load byte A=0x12 -> 0x00000033; load half A=0x12 -> 0x00003344; half A=0x13 -> aligned read 0x00003344, WB_MISALIGN_out=1.
- Store word 0xDEADBEEF at A=0x20, then load word 0x20 next cycle -> 0xDEADBEEF. Store byte 0x5A at 0x21, then load word 0x20 -> 0xDE5ABEEF.
- Store word at A=0x22 (misaligned) -> RAM at 0x20..0x23 unchanged, WB_MISALIGN_out=1. Address 0x1FE word load with ADDR_BITS=8 -> address wraps to 0xFC, aligned.
- Non-memory op: E=0, L=0, ALU_OUT=0x12345678, RD=7 -> WB_DATA_out=0x12345678, misalign=0. MEM_FWD_DATA_out equals 0x12345678 in the same cycle.
- Reset during a store cycle -> all WB outputs 0, target bytes unchanged. PRE_EN together with a pipeline store -> only the preload byte is written.

Source files
------------

// File: rtl/mem_wb_if.sv
// EX/MEM-to-WB bus of the memory stage: pipeline inputs, preload port,
// forwarding value and the registered writeback bundle.
interface mem_wb_if #(
  parameter int ADDR_BITS = 8
);
  logic [31:0]          MEM_RB_in;
  logic [31:0]          MEM_ALU_OUT_in;
  logic [4:0]           MEM_RD_in;
  logic [3:0]           MEM_RAM_CTRL_in;
  logic                 MEM_L_in;
  logic                 MEM_RF_LE_in;
  logic                 PRE_EN;
  logic [ADDR_BITS-1:0] PRE_ADDR;
  logic [7:0]           PRE_DATA;
  logic [31:0]          MEM_FWD_DATA_out;
  logic [31:0]          WB_DATA_out;
  logic [4:0]           WB_RD_out;
  logic                 WB_RF_LE_out;
  logic                 WB_MISALIGN_out;

  modport master (
    output MEM_RB_in, MEM_ALU_OUT_in, MEM_RD_in, MEM_RAM_CTRL_in, MEM_L_in, MEM_RF_LE_in,
    output PRE_EN, PRE_ADDR, PRE_DATA,
    input  MEM_FWD_DATA_out, WB_DATA_out, WB_RD_out, WB_RF_LE_out, WB_MISALIGN_out
  );

  modport slave (
    input  MEM_RB_in, MEM_ALU_OUT_in, MEM_RD_in, MEM_RAM_CTRL_in, MEM_L_in, MEM_RF_LE_in,
    input  PRE_EN, PRE_ADDR, PRE_DATA,
    output MEM_FWD_DATA_out, WB_DATA_out, WB_RD_out, WB_RF_LE_out, WB_MISALIGN_out
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory stage with big-endian byte-wide data RAM and the MEM/WB pipeline register.
// Misaligned loads read the force-aligned address; misaligned stores are dropped.
module mem_wb_stage #(
  parameter int ADDR_BITS = 8
) (
  input  logic     clk,
  input  logic     Reset,
  mem_wb_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]           mem_r [DEPTH];
  logic [31:0]          wb_data_r;
  logic [4:0]           wb_rd_r;
  logic                 wb_rf_le_r;
  logic                 wb_misalign_r;

  logic [ADDR_BITS-1:0] addr_s;
  logic [ADDR_BITS-1:0] base_s;
  logic [ADDR_BITS-1:0] a1_s;
  logic [ADDR_BITS-1:0] a2_s;
  logic [ADDR_BITS-1:0] a3_s;
  logic                 e_s;
  logic                 rw_s;
  logic [1:0]           size_s;
  logic                 misalign_s;
  logic                 is_load_s;
  logic                 store_en_s;
  logic [7:0]           b0_s;
  logic [7:0]           b1_s;
  logic [7:0]           b2_s;
  logic [7:0]           b3_s;
  logic [31:0]          load_data_s;
  logic [31:0]          fwd_data_s;
  logic                 unused_upper_s;

  assign addr_s         = bus.MEM_ALU_OUT_in[ADDR_BITS-1:0];
  assign unused_upper_s = ^bus.MEM_ALU_OUT_in[31:ADDR_BITS];
  assign e_s            = bus.MEM_RAM_CTRL_in[3];
  assign rw_s           = bus.MEM_RAM_CTRL_in[2];
  assign size_s         = bus.MEM_RAM_CTRL_in[1:0];
  assign is_load_s      = e_s & ~rw_s;
  // Preload owns the write port, and reset kills the in-flight store.
  assign store_en_s     = e_s & rw_s & ~misalign_s & ~Reset & ~bus.PRE_EN;

  // Misalignment detection and force-aligned base address.
  always_comb begin
    misalign_s = 1'b0;
    base_s     = addr_s;
    case (size_s)
      2'b00: begin
        misalign_s = 1'b0;
        base_s     = addr_s;
      end
      2'b01: begin
        misalign_s = e_s & addr_s[0];
        base_s     = {addr_s[ADDR_BITS-1:1], 1'b0};
      end
      default: begin
        misalign_s = e_s & (addr_s[1:0] != 2'b00);
        base_s     = {addr_s[ADDR_BITS-1:2], 2'b00};
      end
    endcase
  end

  // Byte lanes wrap modulo the RAM size through the address width.
  assign a1_s = base_s + ADDR_BITS'(1);
  assign a2_s = base_s + ADDR_BITS'(2);
  assign a3_s = base_s + ADDR_BITS'(3);
  assign b0_s = mem_r[base_s];
  assign b1_s = mem_r[a1_s];
  assign b2_s = mem_r[a2_s];
  assign b3_s = mem_r[a3_s];

  // Zero-extended big-endian load data; zero when no load is active.
  always_comb begin
    load_data_s = 32'd0;
    if (is_load_s) begin
      case (size_s)
        2'b00:   load_data_s = {24'd0, b0_s};
        2'b01:   load_data_s = {16'd0, b0_s, b1_s};
        default: load_data_s = {b0_s, b1_s, b2_s, b3_s};
      endcase
    end else begin
      load_data_s = 32'd0;
    end
  end

  assign fwd_data_s           = bus.MEM_L_in ? load_data_s : bus.MEM_ALU_OUT_in;
  assign bus.MEM_FWD_DATA_out = fwd_data_s;

  // Data RAM write port: preload first, then pipeline stores.
  always_ff @(posedge clk) begin
    if (bus.PRE_EN) begin
      mem_r[bus.PRE_ADDR] <= bus.PRE_DATA;
    end else if (store_en_s) begin
      case (size_s)
        2'b00: begin
          mem_r[base_s] <= bus.MEM_RB_in[7:0];
        end
        2'b01: begin
          mem_r[base_s] <= bus.MEM_RB_in[15:8];
          mem_r[a1_s]   <= bus.MEM_RB_in[7:0];
        end
        default: begin
          mem_r[base_s] <= bus.MEM_RB_in[31:24];
          mem_r[a1_s]   <= bus.MEM_RB_in[23:16];
          mem_r[a2_s]   <= bus.MEM_RB_in[15:8];
          mem_r[a3_s]   <= bus.MEM_RB_in[7:0];
        end
      endcase
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wb_data_r     <= 32'd0;
      wb_rd_r       <= 5'd0;
      wb_rf_le_r    <= 1'b0;
      wb_misalign_r <= 1'b0;
    end else begin
      wb_data_r     <= fwd_data_s;
      wb_rd_r       <= bus.MEM_RD_in;
      wb_rf_le_r    <= bus.MEM_RF_LE_in;
      wb_misalign_r <= misalign_s;
    end
  end

  assign bus.WB_DATA_out     = wb_data_r;
  assign bus.WB_RD_out       = wb_rd_r;
  assign bus.WB_RF_LE_out    = wb_rf_le_r;
  assign bus.WB_MISALIGN_out = wb_misalign_r;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed ops push hand-computed expectations,
// a monitor pops them one cycle later and compares the WB bundle and forwarded value.
module tb_mem_wb_stage;
  logic clk;
  logic Reset;
  logic vld;

  mem_wb_if #(.ADDR_BITS(8)) bus ();

  mem_wb_stage #(.ADDR_BITS(8)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] fwd;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rf_le;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  logic       pre_en_v;
  logic [7:0] pre_addr_v;
  logic [7:0] pre_data_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    vld                 = 1'b0;
    bus.MEM_RAM_CTRL_in = 4'b0000;
    bus.PRE_EN          = 1'b1;
    bus.PRE_ADDR        = a;
    bus.PRE_DATA        = d;
  endtask

  // One pipeline instruction; optional preload from pre_*_v in the same cycle.
  task automatic op(input string nm, input logic rst, input logic [3:0] ctrl,
                    input logic [31:0] alu, input logic [31:0] rb, input logic [4:0] rd,
                    input logic l, input logic rfle, input logic [31:0] exp_fwd,
                    input logic [31:0] exp_data, input logic exp_mis);
    exp_t e;
    @(negedge clk);
    Reset               = rst;
    bus.MEM_RAM_CTRL_in = ctrl;
    bus.MEM_ALU_OUT_in  = alu;
    bus.MEM_RB_in       = rb;
    bus.MEM_RD_in       = rd;
    bus.MEM_L_in        = l;
    bus.MEM_RF_LE_in    = rfle;
    bus.PRE_EN          = pre_en_v;
    bus.PRE_ADDR        = pre_addr_v;
    bus.PRE_DATA        = pre_data_v;
    pre_en_v            = 1'b0;
    e.name  = nm;
    e.fwd   = exp_fwd;
    e.data  = rst ? 32'd0 : exp_data;
    e.rd    = rst ? 5'd0 : rd;
    e.rf_le = rst ? 1'b0 : rfle;
    e.mis   = rst ? 1'b0 : exp_mis;
    exp_q.push_back(e);
    vld = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    vld                 = 1'b0;
    Reset               = 1'b0;
    bus.MEM_RAM_CTRL_in = 4'b0000;
    bus.MEM_L_in        = 1'b0;
    bus.MEM_RF_LE_in    = 1'b0;
    bus.PRE_EN          = 1'b0;
  endtask

  // Monitor: forwarded value sampled before the edge, WB bundle just after it.
  initial begin : monitor
    logic        v;
    logic [31:0] f;
    exp_t        e;
    forever begin
      @(posedge clk);
      v = vld;
      f = bus.MEM_FWD_DATA_out;
      #1;
      if (v) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard: output with empty queue");
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (f !== e.fwd) begin
            miscompares++;
            $display("FAIL %s fwd: got %h, want %h", e.name, f, e.fwd);
          end
          vectors++;
          if ({bus.WB_DATA_out, bus.WB_RD_out, bus.WB_RF_LE_out, bus.WB_MISALIGN_out} !==
              {e.data, e.rd, e.rf_le, e.mis}) begin
            miscompares++;
            $display("FAIL %s wb: got data=%h rd=%0d le=%b mis=%b, want data=%h rd=%0d le=%b mis=%b",
                     e.name, bus.WB_DATA_out, bus.WB_RD_out, bus.WB_RF_LE_out,
                     bus.WB_MISALIGN_out, e.data, e.rd, e.rf_le, e.mis);
          end
        end
      end
    end
  end

  initial begin : stim
    int budget;
    vectors     = 0;
    miscompares = 0;
    vld         = 1'b0;
    Reset       = 1'b1;
    pre_en_v    = 1'b0;
    pre_addr_v  = 8'h00;
    pre_data_v  = 8'h00;
    bus.MEM_RB_in       = 32'd0;
    bus.MEM_ALU_OUT_in  = 32'd0;
    bus.MEM_RD_in       = 5'd0;
    bus.MEM_RAM_CTRL_in = 4'b0000;
    bus.MEM_L_in        = 1'b0;
    bus.MEM_RF_LE_in    = 1'b0;
    bus.PRE_EN          = 1'b0;
    bus.PRE_ADDR        = 8'h00;
    bus.PRE_DATA        = 8'h00;

    // Reset state: WB zero, forwarding still follows the ALU value.
    op("reset", 1'b1, 4'b0000, 32'hCAFE0000, 32'd0, 5'd9, 1'b0, 1'b1, 32'hCAFE0000, 32'd0, 1'b0);

    preload(8'h10, 8'h11); preload(8'h11, 8'h22); preload(8'h12, 8'h33); preload(8'h13, 8'h44);
    preload(8'hFC, 8'hA1); preload(8'hFD, 8'hB2); preload(8'hFE, 8'hC3); preload(8'hFF, 8'hD4);

    op("ldw_10",   1'b0, 4'b1010, 32'h10, 32'd0, 5'd5, 1'b1, 1'b1, 32'h11223344, 32'h11223344, 1'b0);
    op("ldb_12",   1'b0, 4'b1000, 32'h12, 32'd0, 5'd6, 1'b1, 1'b1, 32'h00000033, 32'h00000033, 1'b0);
    op("ldh_12",   1'b0, 4'b1001, 32'h12, 32'd0, 5'd6, 1'b1, 1'b1, 32'h00003344, 32'h00003344, 1'b0);
    op("ldh_13",   1'b0, 4'b1001, 32'h13, 32'd0, 5'd6, 1'b1, 1'b1, 32'h00003344, 32'h00003344, 1'b1);
    op("ld11_10",  1'b0, 4'b1011, 32'h10, 32'd0, 5'd1, 1'b1, 1'b1, 32'h11223344, 32'h11223344, 1'b0);
    op("ldw_11",   1'b0, 4'b1010, 32'h11, 32'd0, 5'd2, 1'b1, 1'b1, 32'h11223344, 32'h11223344, 1'b1);

    op("stw_20",   1'b0, 4'b1110, 32'h20, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 32'h20, 32'h20, 1'b0);
    op("ldw_20a",  1'b0, 4'b1010, 32'h20, 32'd0, 5'd4, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    op("stb_21",   1'b0, 4'b1100, 32'h21, 32'hFFFFFF5A, 5'd0, 1'b0, 1'b0, 32'h21, 32'h21, 1'b0);
    op("ldw_20b",  1'b0, 4'b1010, 32'h20, 32'd0, 5'd4, 1'b1, 1'b1, 32'hDE5ABEEF, 32'hDE5ABEEF, 1'b0);
    op("sth_22",   1'b0, 4'b1101, 32'h22, 32'hAAAA1234, 5'd0, 1'b0, 1'b0, 32'h22, 32'h22, 1'b0);
    op("ldw_20c",  1'b0, 4'b1010, 32'h20, 32'd0, 5'd4, 1'b1, 1'b1, 32'hDE5A1234, 32'hDE5A1234, 1'b0);
    op("stw_22mis",1'b0, 4'b1110, 32'h22, 32'h01020304, 5'd0, 1'b0, 1'b0, 32'h22, 32'h22, 1'b1);
    op("ldw_20d",  1'b0, 4'b1010, 32'h20, 32'd0, 5'd4, 1'b1, 1'b1, 32'hDE5A1234, 32'hDE5A1234, 1'b0);

    op("ldw_1fe",  1'b0, 4'b1010, 32'h1FE, 32'd0, 5'd8, 1'b1, 1'b1, 32'hA1B2C3D4, 32'hA1B2C3D4, 1'b1);
    op("ldb_1ff",  1'b0, 4'b1000, 32'h1FF, 32'd0, 5'd8, 1'b1, 1'b1, 32'h000000D4, 32'h000000D4, 1'b0);

    op("alu_op",   1'b0, 4'b0000, 32'h12345678, 32'd0, 5'd7, 1'b0, 1'b1, 32'h12345678, 32'h12345678, 1'b0);
    op("e0_load",  1'b0, 4'b0000, 32'h10, 32'd0, 5'd3, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);

    // Reset kills the store but the same-cycle preload lands.
    pre_en_v = 1'b1; pre_addr_v = 8'h41; pre_data_v = 8'h99;
    op("rst_store",1'b1, 4'b1110, 32'h10, 32'h55555555, 5'd3, 1'b0, 1'b1, 32'h10, 32'h10, 1'b0);
    op("ldw_10b",  1'b0, 4'b1010, 32'h10, 32'd0, 5'd5, 1'b1, 1'b1, 32'h11223344, 32'h11223344, 1'b0);
    op("ldb_41",   1'b0, 4'b1000, 32'h41, 32'd0, 5'd5, 1'b1, 1'b1, 32'h00000099, 32'h00000099, 1'b0);

    // Preload wins the write port over a pipeline store.
    pre_en_v = 1'b1; pre_addr_v = 8'h40; pre_data_v = 8'h77;
    op("pre_store",1'b0, 4'b1110, 32'hFC, 32'h88888888, 5'd0, 1'b0, 1'b0, 32'hFC, 32'hFC, 1'b0);
    op("ldw_fc",   1'b0, 4'b1010, 32'hFC, 32'd0, 5'd9, 1'b1, 1'b1, 32'hA1B2C3D4, 32'hA1B2C3D4, 1'b0);
    op("ldb_40",   1'b0, 4'b1000, 32'h40, 32'd0, 5'd9, 1'b1, 1'b1, 32'h00000077, 32'h00000077, 1'b0);

    idle();
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
